tag_mem_backend: RTL

- Behavioural main-memory backend directly downstream of the tag cache.
- Consumes the cache's memory command, write-data and read-response channels; stores whole blocks in an internal array.
- Returns read blocks beat-by-beat after a programmable latency.
- Used in the simulation top in place of the bench-driven memory handshakes. Commands are serviced strictly in order, one at a time.

---
 rtl/tag_mem_backend.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tag_mem_backend.sv
// Behavioural main-memory backend sitting below the tag cache.
// Commands are queued in a small FIFO and serviced strictly in order:
// writes consume BeatsPerBlock data beats, reads return a block
// beat-by-beat after a fixed latency. No response is produced for writes.
module tag_mem_backend #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TagWidth      = 5,
    parameter int unsigned DataWidth     = 128,
    parameter int unsigned BeatsPerBlock = 4,
    parameter int unsigned Latency       = 4,
    parameter int unsigned MemDepth      = 1024,
    parameter int unsigned CmdQDepth     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [TagWidth-1:0]  req_tag,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DataWidth-1:0] wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DataWidth-1:0] resp_data,
    output logic [TagWidth-1:0]  resp_tag
);

    localparam int unsigned IdxW  = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam int unsigned BeatW = $clog2(BeatsPerBlock);
    localparam int unsigned PtrW  = (CmdQDepth > 1) ? $clog2(CmdQDepth) : 1;
    localparam int unsigned LatW  = $clog2(Latency) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Command FIFO
    logic                 q_rw   [CmdQDepth];
    logic [AddrWidth-1:0] q_addr [CmdQDepth];
    logic [TagWidth-1:0]  q_tag  [CmdQDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW:0]        count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // Transaction state
    logic [1:0]           state;
    logic [BeatW-1:0]     beat;
    logic [LatW-1:0]      lat_cnt;
    logic [IdxW-1:0]      blk_q;
    logic [TagWidth-1:0]  tag_q;
    logic [IdxW-1:0]      head_blk;
    logic                 last_beat;

    // Block storage: one flat word per beat, indexed {block, beat}.
    // Contents start at zero and are deliberately untouched by reset.
    logic [DataWidth-1:0] mem [MemDepth*BeatsPerBlock] = '{default: '0};

    assign full      = (count == (PtrW+1)'(CmdQDepth));
    assign empty     = (count == '0);
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head_blk  = IdxW'(q_addr[rd_ptr] % AddrWidth'(MemDepth));
    assign last_beat = (beat == BeatW'(BeatsPerBlock - 1));

    assign req_ready   = !full;
    assign wdata_ready = (state == WDATA);
    assign resp_valid  = (state == RESP);
    assign resp_data   = resp_valid ? mem[{blk_q, beat}] : '0;
    assign resp_tag    = resp_valid ? tag_q : '0;

    // FIFO payload storage; contents of empty slots are don't-care
    always_ff @(posedge clk) begin
        if (push) begin
            q_rw[wr_ptr]   <= req_rw;
            q_addr[wr_ptr] <= req_addr;
            q_tag[wr_ptr]  <= req_tag;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Command sequencer: pop, then move write beats in or read beats out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            beat    <= '0;
            lat_cnt <= '0;
            blk_q   <= '0;
            tag_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        blk_q <= head_blk;
                        tag_q <= q_tag[rd_ptr];
                        beat  <= '0;
                        if (q_rw[rd_ptr]) begin
                            state <= WDATA;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LatW'(Latency - 1);
                        end
                    end
                end
                WDATA: begin
                    if (wdata_valid) begin
                        beat <= beat + 1'b1;
                        if (last_beat) state <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        beat  <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        beat <= beat + 1'b1;
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-beat capture; only beats handshaken in WDATA reach the array
    always_ff @(posedge clk) begin
        if ((state == WDATA) && wdata_valid) begin
            mem[{blk_q, beat}] <= wdata;
        end
    end

endmodule
